fullconnect_write_master: RTL and testbench

FULLCONNECT_WRITE_MASTER -- requirements
Module: fullconnect_write_master

---
 rtl/fullconnect_pkg.sv | 18 +
 rtl/fullconnect_write_master.sv | 110 +++++++++++
 tb/tb_fullconnect_write_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fullconnect_pkg.sv
// Shared definitions for the fully-connected layer Avalon-MM write master.
package fullconnect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 512;
  localparam int unsigned BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;

  function automatic int unsigned bytes_per_beat(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/fullconnect_write_master.sv
// Avalon-MM write master: drains a write buffer into consecutive beat-aligned
// addresses, one handshake per beat, with a one-cycle Done_o pulse per job.
module fullconnect_write_master
  import fullconnect_pkg::*;
#(
  parameter int unsigned AvalonData_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          Start_i,
  input  logic [ADDR_WIDTH-1:0]         BaseAddr_i,
  input  logic [15:0]                   Count_i,
  output logic                          Busy_o,
  output logic                          Done_o,
  input  logic                          WriteReq_i,
  input  logic [AvalonData_WIDTH-1:0]   WriteData_i,
  output logic                          WriteAck_o,
  output logic [ADDR_WIDTH-1:0]         avm_address,
  output logic                          avm_write,
  output logic [AvalonData_WIDTH-1:0]   avm_writedata,
  output logic [AvalonData_WIDTH/8-1:0] avm_byteenable,
  input  logic                          avm_waitrequest
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP =
    ADDR_WIDTH'(bytes_per_beat(AvalonData_WIDTH));

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [15:0]                   remaining;
  logic [AvalonData_WIDTH-1:0]   data;
  logic                          write_q;
  logic                          busy_q;
  logic                          done_q;

  // Status outputs are registered alongside the state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      data      <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (Start_i) begin
            addr      <= BaseAddr_i;
            remaining <= Count_i;
            busy_q    <= 1'b1;
            if (Count_i == 16'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= WAIT_REQ;
            end
          end
        end
        WAIT_REQ: begin
          if (WriteReq_i) begin
            data    <= WriteData_i;
            write_q <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            addr      <= addr + ADDR_STEP;
            remaining <= remaining - 16'd1;
            write_q   <= 1'b0;
            if (remaining == 16'd1) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= WAIT_REQ;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    WriteAck_o = (state == WAIT_REQ) && WriteReq_i;
  end

  assign Busy_o         = busy_q;
  assign Done_o         = done_q;
  assign avm_write      = write_q;
  assign avm_address    = addr;
  assign avm_writedata  = data;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_fullconnect_write_master.sv
// Directed bench for fullconnect_write_master with a scoreboard of expected beats.
module tb_fullconnect_write_master;

  localparam int unsigned DW  = 512;
  localparam int unsigned AW  = 32;
  localparam int unsigned BPB = DW / 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            Start_i;
  logic [AW-1:0]   BaseAddr_i;
  logic [15:0]     Count_i;
  logic            Busy_o;
  logic            Done_o;
  logic            WriteReq_i;
  logic [DW-1:0]   WriteData_i;
  logic            WriteAck_o;
  logic [AW-1:0]   avm_address;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_waitrequest;

  fullconnect_write_master #(
    .AvalonData_WIDTH(DW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .Start_i        (Start_i),
    .BaseAddr_i     (BaseAddr_i),
    .Count_i        (Count_i),
    .Busy_o         (Busy_o),
    .Done_o         (Done_o),
    .WriteReq_i     (WriteReq_i),
    .WriteData_i    (WriteData_i),
    .WriteAck_o     (WriteAck_o),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] acc_addr[$];
  logic [AW-1:0] model_addr;
  int            checks     = 0;
  int            failures   = 0;
  int            cyc        = 0;
  int            start_cyc  = 0;
  int            done_cyc   = 0;
  int            done_cnt   = 0;
  int            ack_cnt    = 0;
  int            beat_cnt   = 0;
  int            wr_cycles  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pushes expected beats on each ack, checks and retires them on accept.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (WriteAck_o) begin
        exp_q.push_back('{model_addr, WriteData_i});
        model_addr = model_addr + AW'(BPB);
        ack_cnt++;
      end else begin
        for (int i = 0; i < DW / 32; i++) WriteData_i[i*32 +: 32] = $urandom;
      end
      if (avm_write) begin
        wr_cycles++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $error("FAIL unexpected_write observed=%0h expected=none", avm_address);
        end else begin
          assert (avm_address === exp_q[0].addr)
          else begin
            failures++;
            $error("FAIL write_addr observed=%0h expected=%0h", avm_address, exp_q[0].addr);
          end
          checks++;
          assert (avm_writedata === exp_q[0].data)
          else begin
            failures++;
            $error("FAIL write_data observed=%0h expected=%0h", avm_writedata, exp_q[0].data);
          end
          if (!avm_waitrequest) begin
            acc_addr.push_back(avm_address);
            void'(exp_q.pop_front());
            beat_cnt++;
          end
        end
      end
      if (Done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!Busy_o) begin
        checks++;
        assert ({WriteAck_o, avm_write, Done_o} === 3'b000)
        else begin
          failures++;
          $error("FAIL idle_quiet observed=%b expected=000", {WriteAck_o, avm_write, Done_o});
        end
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] base, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    Start_i    = 1'b1;
    BaseAddr_i = base;
    Count_i    = cnt;
    model_addr = base;
    start_cyc  = cyc;
    acc_addr.delete();
    @(posedge clk);
    #1;
    Start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (done_cnt != d0)
    else begin
      failures++;
      $error("FAIL %s_done_timeout observed=%0d expected=%0d", tag, done_cnt, d0 + 1);
    end
  endtask

  int a0, b0, d0, w0, n;

  initial begin
    rstn            = 1'b0;
    Start_i         = 1'b0;
    BaseAddr_i      = '0;
    Count_i         = '0;
    WriteReq_i      = 1'b0;
    WriteData_i     = '0;
    avm_waitrequest = 1'b0;
    model_addr      = '0;
    #1;
    chk("rst_busy", DW'(Busy_o), '0);
    chk("rst_done", DW'(Done_o), '0);
    chk("rst_write", DW'(avm_write), '0);
    chk("rst_ack", DW'(WriteAck_o), '0);
    chk("rst_addr", DW'(avm_address), '0);
    chk("rst_data", avm_writedata, '0);
    chk("rst_be", DW'(avm_byteenable), {(DW/8){1'b1}});
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Basic job: three beats, request held, no stall.
    WriteReq_i = 1'b1;
    a0 = ack_cnt; b0 = beat_cnt; d0 = done_cnt;
    start_job(32'h0000_1000, 16'd3);
    wait_done("basic", 50);
    chk("basic_latency", DW'(done_cyc - start_cyc), DW'(7));
    chk("basic_acks", DW'(ack_cnt - a0), DW'(3));
    chk("basic_beats", DW'(beat_cnt - b0), DW'(3));
    chk("basic_addr0", DW'(acc_addr[0]), DW'(32'h0000_1000));
    chk("basic_addr1", DW'(acc_addr[1]), DW'(32'h0000_1040));
    chk("basic_addr2", DW'(acc_addr[2]), DW'(32'h0000_1080));
    repeat (3) @(posedge clk);
    #1;
    chk("basic_done_pulses", DW'(done_cnt - d0), DW'(1));
    chk("basic_idle_busy", DW'(Busy_o), '0);
    chk("basic_queue_empty", DW'(exp_q.size()), '0);

    // Stall: waitrequest held for the first four write cycles of beat 1.
    avm_waitrequest = 1'b1;
    b0 = beat_cnt; w0 = wr_cycles;
    start_job(32'h0000_4000, 16'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_write && n < 20);
    chk("stall_write_seen", DW'(avm_write), DW'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("stall_beats_held", DW'(beat_cnt - b0), '0);
    avm_waitrequest = 1'b0;
    wait_done("stall", 50);
    chk("stall_latency", DW'(done_cyc - start_cyc), DW'(9));
    chk("stall_wr_cycles", DW'(wr_cycles - w0), DW'(6));
    chk("stall_beats", DW'(beat_cnt - b0), DW'(2));

    // Zero count: immediate completion, no traffic.
    a0 = ack_cnt; w0 = wr_cycles;
    start_job(32'h0000_8000, 16'd0);
    wait_done("zero", 10);
    chk("zero_latency", DW'(done_cyc - start_cyc), DW'(1));
    chk("zero_acks", DW'(ack_cnt - a0), '0);
    chk("zero_writes", DW'(wr_cycles - w0), '0);

    // Address wrap at the top of the address space.
    start_job(32'hFFFF_FFC0, 16'd2);
    wait_done("wrap", 50);
    chk("wrap_addr0", DW'(acc_addr[0]), DW'(32'hFFFF_FFC0));
    chk("wrap_addr1", DW'(acc_addr[1]), DW'(32'h0000_0000));

    // Start while busy is ignored; reset mid-WRITE abandons the job.
    d0 = done_cnt;
    start_job(32'h0000_2000, 16'd4);
    Start_i    = 1'b1;
    BaseAddr_i = 32'h0000_9000;
    Count_i    = 16'd1;
    repeat (2) @(posedge clk);
    #1;
    Start_i = 1'b0;
    n = 0;
    while (acc_addr.size() < 2 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk("busy_start_beats", DW'(acc_addr.size()), DW'(2));
    chk("busy_start_addr0", DW'(acc_addr[0]), DW'(32'h0000_2000));
    chk("busy_start_addr1", DW'(acc_addr[1]), DW'(32'h0000_2040));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_write && n < 20);
    chk("midrst_write_seen", DW'(avm_write), DW'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_write", DW'(avm_write), '0);
    chk("midrst_busy", DW'(Busy_o), '0);
    chk("midrst_done", DW'(Done_o), '0);
    chk("midrst_ack", DW'(WriteAck_o), '0);
    chk("midrst_addr", DW'(avm_address), '0);
    chk("midrst_data", avm_writedata, '0);
    chk("midrst_be", DW'(avm_byteenable), {(DW/8){1'b1}});
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", DW'(done_cnt - d0), '0);

    // Fresh job after reset completes normally.
    start_job(32'h0000_3000, 16'd2);
    wait_done("fresh", 50);
    chk("fresh_latency", DW'(done_cyc - start_cyc), DW'(5));
    chk("fresh_addr0", DW'(acc_addr[0]), DW'(32'h0000_3000));
    chk("fresh_addr1", DW'(acc_addr[1]), DW'(32'h0000_3040));
    repeat (2) @(posedge clk);
    #1;
    chk("fresh_queue_empty", DW'(exp_q.size()), '0);
    chk("fresh_done_pulses", DW'(done_cnt - d0), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
